io_mmio_uart: RTL
=================

Name: io_mmio_uart

Overview:
- Memory-mapped IO slave attached to the MIPS150 datapath X/M boundary; replaces the constant dummy IO load word with real IO read data.
- Address, byte-lane write strobes and store data are presented in X stage; read data is registered and returned in M stage, giving the same one-cycle latency as DMEM.
- Contains a UART transmitter, a UART receiver with a one-byte holding buffer, and cycle/instruction counters.

Parameters:
- CLOCK_FREQ, 50_000_000, core clock frequency in Hz.
- BAUD_RATE, 115_200, UART bit rate.
- Derived value, not overridable: SYMBOL_EDGE_TIME = CLOCK_FREQ/BAUD_RATE, in clocks per bit (integer divide).

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- io_addr  in  32  X-stage ALU result. Only bits [7:2] are decoded; the top-nibble decode is done outside this block.
- io_we  in  4  X-stage IO store mask from the memory map; big-endian, bit0 = byte lane [7:0].
- io_wdata  in  32  X-stage store data (rt register value).
- io_re  in  1  X-stage load targeting IO (load instruction AND IO address region).
- io_rdata  out  32  registered read data, valid in the M stage of the load.
- instr_retire  in  1  one pulse per instruction leaving M.
- serial_in  in  1  UART RX line, asynchronous.
- serial_out  out  1  UART TX line, idle high.

Behaviour:
- Reset values: io_rdata=0, serial_out=1, tx FSM IDLE, rx FSM IDLE, rx_valid=0, overrun=0, counters=0.
- Register map (word offsets; unlisted offsets read 0 and ignore writes):
  - 0x00 CTRL (RO): bit0 tx_ready, bit1 rx_valid, bit2 overrun; all other bits 0.
  - 0x04 RXDATA (RO): bits[7:0] hold the byte, upper bits 0. A read pops the buffer: rx_valid and overrun clear on the next edge.
  - 0x08 TXDATA (WO): on a write with io_we[0]=1 while tx_ready=1, io_wdata[7:0] starts a frame. Writes while busy are dropped silently.
  - 0x10 CYCLE: free-running counter, increments every clock. Any write with io_we!=0 clears it to 0.
  - 0x14 INSTR: increments on each instr_retire. Any write with io_we!=0 clears it to 0.
- Read path: io_rdata is loaded on every edge where io_re=1 with the decoded value; when io_re=0 it holds its value. Latency is exactly 1 clock.
- Simultaneous events:
  - Counter write and increment on the same clock: the clear wins (result 0).
  - Counter read returns the value before that clock's increment.
  - RXDATA read on the same clock a new byte completes: the new byte is latched, rx_valid stays 1, overrun is unchanged.
- TX FSM, states IDLE → START → DATA → STOP → IDLE:
  - Each state lasts SYMBOL_EDGE_TIME clocks.
  - Data bits are sent LSB first through a 3-bit bit counter.
  - tx_ready=1 only in IDLE; it drops on the clock following the accepted write.
  - The frame is 10 bits (start 0, 8 data, stop 1). tx_ready returns after 10*SYMBOL_EDGE_TIME clocks.
- RX FSM, states IDLE → START → DATA → STOP:
  - serial_in passes through a 2-flop synchroniser.
  - Falling edge in IDLE → START. The line is re-sampled at SYMBOL_EDGE_TIME/2; if it is high, the start was a glitch and the FSM returns to IDLE.
  - Each data bit is sampled at its mid-point, every SYMBOL_EDGE_TIME clocks thereafter.
  - STOP sample = 1: the byte is written to the buffer and rx_valid is set. If rx_valid was already 1, the byte overwrites the buffer and overrun is set.
  - STOP sample = 0: framing error; the byte is discarded and the FSM returns to IDLE.
- Counters are 32 bits and wrap from 0xFFFFFFFF to 0 with no flag.
- Reset mid-frame: both FSMs return to IDLE on the same edge, serial_out=1 on the next clock, and partial bytes are lost.

Optional Feature:
- IO_COUNTERS_EN defined: CYCLE and INSTR counters are present as described above.
- IO_COUNTERS_EN undefined: no counter flops are built; offsets 0x10/0x14 read 0, writes are ignored, and instr_retire is unused.

Test Plan:
- Use CLOCK_FREQ=1000, BAUD_RATE=100 (10 clk/bit) for all scenarios.
- TX: io_we=4'b1111, addr 0x08, wdata 0x000000A5 → CTRL reads 0 on the next load. serial_out shows 0, 1,0,1,0,0,1,0,1, 1 at 10-clk intervals. tx_ready=1 exactly 100 clocks after the write; a second write 0x3C during the frame is not transmitted.
- RX: drive frame 0x5A on serial_in → CTRL=0x2 (rx_valid). RXDATA load returns 0x0000005A one clock after io_re, then CTRL=0x0.
- Overrun and framing: send 0x11 then 0x22 without reading → RXDATA=0x22 and CTRL bit2=1. A frame with stop bit 0 → rx_valid stays 0.
- Counters (IO_COUNTERS_EN defined): 50 clocks after reset, CYCLE reads 50 ±1. Three instr_retire pulses → INSTR=3. SW to 0x14 → INSTR=0 on the next read.
- Reset at bit 4 of an RX frame and mid TX frame → rx_valid=0, serial_out=1 one clock after the rst edge, CTRL=0x1.
- Unmapped offset 0x1C read → io_rdata=0. io_re=0 for 5 clocks → io_rdata holds its previous value.

Source files
------------

// File: rtl/io_mmio_uart.sv
// io_mmio_uart: memory-mapped UART (tx, rx + one-byte buffer) and cycle/instr
// counters at the MIPS150 X/M boundary; read data returns one clock after io_re.
// Define IO_COUNTERS_EN to build the CYCLE/INSTR counters at 0x10/0x14.
module io_mmio_uart #(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] io_addr,
    input  logic [3:0]  io_we,
    input  logic [31:0] io_wdata,
    input  logic        io_re,
    output logic [31:0] io_rdata,
    input  logic        instr_retire,
    input  logic        serial_in,
    output logic        serial_out
);
    localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
    localparam int CW = $clog2(SYMBOL_EDGE_TIME + 1);
    localparam logic [CW-1:0] LAST = CW'(SYMBOL_EDGE_TIME - 1);
    localparam logic [CW-1:0] HALF = CW'(SYMBOL_EDGE_TIME / 2);
    localparam logic [1:0] IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3;

    logic [5:0] off;
    logic tx_ready, tx_wr, rx_pop, rx_done;
    logic [31:0] rd_val, rd_cycle, rd_instr, io_rdata_d, io_rdata_q;
    logic [1:0] tx_state_d, tx_state_q, rx_state_d, rx_state_q;
    logic [CW-1:0] tx_cnt_d, tx_cnt_q, rx_cnt_d, rx_cnt_q;
    logic [2:0] tx_bit_d, tx_bit_q, rx_bit_d, rx_bit_q;
    logic [7:0] tx_shift_d, tx_shift_q, rx_shift_d, rx_shift_q, rx_data_d, rx_data_q;
    logic serial_out_d, serial_out_q, rx_s1_q, rx_s2_q, rx_prev_q;
    logic rx_valid_d, rx_valid_q, overrun_d, overrun_q;
    logic unused_bits;

    assign off         = io_addr[7:2];
    assign tx_ready    = tx_state_q == IDLE;
    assign tx_wr       = io_we[0] && off == 6'h02 && tx_ready;
    assign rx_pop      = io_re && off == 6'h01;
    assign rx_done     = rx_state_q == STOP && rx_cnt_q == LAST && rx_s2_q;
    assign io_rdata    = io_rdata_q;
    assign serial_out  = serial_out_q;
    assign unused_bits = &{1'b0, io_addr[31:8], io_addr[1:0], io_wdata[31:8], io_we[3:1]};

    // TX: start, 8 data bits LSB first, stop; each symbol held SYMBOL_EDGE_TIME clocks
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + CW'(1);
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        if (tx_state_q == IDLE) begin
            tx_cnt_d = '0;
            if (tx_wr) begin
                tx_state_d = START;
                tx_shift_d = io_wdata[7:0];
            end
        end else if (tx_cnt_q == LAST) begin
            tx_cnt_d = '0;
            if (tx_state_q == START) begin
                tx_state_d = DATA;
                tx_bit_d   = '0;
            end else if (tx_state_q == DATA) begin
                tx_shift_d = tx_shift_q >> 1;
                tx_bit_d   = tx_bit_q + 3'd1;
                if (tx_bit_q == 3'd7) tx_state_d = STOP;
            end else begin
                tx_state_d = IDLE;
            end
        end
        serial_out_d = tx_state_d == START ? 1'b0 : tx_state_d == DATA ? tx_shift_d[0] : 1'b1;
    end

    // RX: falling edge starts a frame, half-symbol start recheck, then mid-bit samples
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + CW'(1);
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        if (rx_state_q == IDLE) begin
            rx_cnt_d = '0;
            if (rx_prev_q && !rx_s2_q) rx_state_d = START;
        end else if (rx_state_q == START) begin
            if (rx_cnt_q == HALF) begin
                rx_cnt_d   = '0;
                rx_bit_d   = '0;
                rx_state_d = rx_s2_q ? IDLE : DATA;
            end
        end else if (rx_cnt_q == LAST) begin
            rx_cnt_d = '0;
            if (rx_state_q == DATA) begin
                rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                rx_bit_d   = rx_bit_q + 3'd1;
                if (rx_bit_q == 3'd7) rx_state_d = STOP;
            end else begin
                rx_state_d = IDLE;
            end
        end
    end

    // Holding buffer and read mux; a pop racing a new byte keeps rx_valid and overrun
    always_comb begin
        rx_data_d  = rx_done ? rx_shift_q : rx_data_q;
        rx_valid_d = rx_done | (rx_valid_q & ~rx_pop);
        overrun_d  = rx_done ? (overrun_q | (rx_valid_q & ~rx_pop)) : (overrun_q & ~rx_pop);
        rd_val     = off == 6'h00 ? {29'd0, overrun_q, rx_valid_q, tx_ready} :
                     off == 6'h01 ? {24'd0, rx_data_q} :
                     off == 6'h04 ? rd_cycle :
                     off == 6'h05 ? rd_instr : 32'd0;
        io_rdata_d = io_re ? rd_val : io_rdata_q;
    end

    // State registers; rx line passes a 2-flop synchroniser plus an edge-detect flop
    always_ff @(posedge clk) begin
        if (rst) begin
            io_rdata_q   <= '0;
            tx_state_q   <= IDLE;
            tx_cnt_q     <= '0;
            tx_bit_q     <= '0;
            tx_shift_q   <= '0;
            serial_out_q <= 1'b1;
            rx_state_q   <= IDLE;
            rx_cnt_q     <= '0;
            rx_bit_q     <= '0;
            rx_shift_q   <= '0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            overrun_q    <= 1'b0;
            rx_s1_q      <= 1'b1;
            rx_s2_q      <= 1'b1;
            rx_prev_q    <= 1'b1;
        end else begin
            io_rdata_q   <= io_rdata_d;
            tx_state_q   <= tx_state_d;
            tx_cnt_q     <= tx_cnt_d;
            tx_bit_q     <= tx_bit_d;
            tx_shift_q   <= tx_shift_d;
            serial_out_q <= serial_out_d;
            rx_state_q   <= rx_state_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_bit_q     <= rx_bit_d;
            rx_shift_q   <= rx_shift_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            overrun_q    <= overrun_d;
            rx_s1_q      <= serial_in;
            rx_s2_q      <= rx_s1_q;
            rx_prev_q    <= rx_s2_q;
        end
    end

`ifdef IO_COUNTERS_EN
    logic [31:0] cycle_d, cycle_q, instr_d, instr_q;

    // Counters wrap freely; a write to the counter's offset beats that clock's increment
    always_comb begin
        cycle_d = (|io_we && off == 6'h04) ? 32'd0 : cycle_q + 32'd1;
        instr_d = (|io_we && off == 6'h05) ? 32'd0 : instr_q + {31'd0, instr_retire};
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_q <= '0;
            instr_q <= '0;
        end else begin
            cycle_q <= cycle_d;
            instr_q <= instr_d;
        end
    end

    assign rd_cycle = cycle_q;
    assign rd_instr = instr_q;
`else
    logic unused_retire;
    assign unused_retire = instr_retire;
    assign rd_cycle      = '0;
    assign rd_instr      = '0;
`endif
endmodule
